// File: rtl/shift_exec_stage_pkg.sv
// Shared decode constants and helpers for the MIPS shift execute stage.
// Holds funct codes, shifter control encodings and the decoded S1 record.
package shift_exec_stage_pkg;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    localparam logic [1:0] T_SLL = 2'b10;
    localparam logic [1:0] T_SRL = 2'b00;
    localparam logic [1:0] T_SRA = 2'b01;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  t;
        logic [4:0]  rd;
        logic        err;
    } dec_t;

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    function automatic dec_t decode(input logic [5:0]  funct,
                                    input logic [4:0]  shamt,
                                    input logic [4:0]  rs_amt,
                                    input logic [31:0] rt_data,
                                    input logic [4:0]  rd);
        dec_t r;
        r.d   = rt_data;
        r.s   = shamt;
        r.t   = T_SRL;
        r.rd  = rd;
        r.err = 1'b0;
        case (funct)
            FN_SLL:  r.t = T_SLL;
            FN_SRL:  r.t = T_SRL;
            FN_SRA:  r.t = T_SRA;
            FN_SLLV: begin r.t = T_SLL; r.s = rs_amt; end
            FN_SRLV: begin r.t = T_SRL; r.s = rs_amt; end
            FN_SRAV: begin r.t = T_SRA; r.s = rs_amt; end
            default: begin r.err = 1'b1; r.s = 5'd0; r.d = 32'd0; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_stage_shifter32.sv
// 32-bit logarithmic barrel shifter: left, logical right, arithmetic right.
// Purely combinational, zero latency, no flow control.
// Left shifts reuse the right-shift network on a bit-reversed operand.
module shifter32
    import shift_exec_stage_pkg::*;
(
    input  logic [31:0] d,
    input  logic [4:0]  s,
    input  logic [1:0]  t,
    output logic [31:0] r
);

    logic [31:0] x;
    logic        fill;

    always_comb begin
        x    = (t == T_SLL) ? bitrev32(d) : d;
        fill = (t == T_SRA) && d[31];
        for (int i = 0; i < 5; i++) begin
            if (s[i]) begin
                x = (x >> (1 << i)) | (fill ? ~(32'hFFFF_FFFF >> (1 << i)) : 32'h0);
            end
        end
        r = (t == T_SLL) ? bitrev32(x) : x;
    end

endmodule

// File: rtl/shift_exec_stage.sv
// MIPS R-type shift execute stage: decode -> S1 -> barrel shifter -> S2.
// Latency: accepted at edge N, result visible after edge N+1.
// Backpressure: S2 holds while out_ready low, S1 fills, then in_ready drops.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int ZERO_RD_SUPPRESS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_err
);

    dec_t        dec_n;
    dec_t        s1_q;
    logic        s1_valid;
    logic        s2_valid;
    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;
    logic        s1_we;
    logic [31:0] shift_r;
    logic        unused_rs_hi;

    // Only the low five bits of rs act as a shift amount.
    assign unused_rs_hi = ^rs_data[31:5];

    assign dec_n    = decode(funct, shamt, rs_data[4:0], rt_data, rd);
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign s1_adv   = s1_valid && s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign s1_we    = !s1_q.err && !((ZERO_RD_SUPPRESS != 0) && (s1_q.rd == 5'd0));

    shifter32 u_shifter (
        .d (s1_q.d),
        .s (s1_q.s),
        .t (s1_q.t),
        .r (shift_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            out_data <= 32'd0;
            out_rd   <= 5'd0;
            out_we   <= 1'b0;
            out_err  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_q     <= dec_n;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            // S2 payload only changes on a load, keeping it stable under stall.
            if (s1_adv) begin
                s2_valid <= 1'b1;
                out_data <= s1_q.err ? 32'd0 : shift_r;
                out_rd   <= s1_q.rd;
                out_we   <= s1_we;
                out_err  <= s1_q.err;
            end else if (s2_valid && out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule
